// File: rtl/dense_pkg.sv
// dense_pkg: shared constants for the dense block and its argmax classification stage
// Holds score/index widths, class count, argmax FSM state type and class label constants.
package dense_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int NUM_CLASS  = 7;
  localparam int IDX_WIDTH  = 3;
  typedef enum logic {IDLE, SCAN} state_t;
  localparam logic [IDX_WIDTH-1:0] CLS_0 = IDX_WIDTH'(0);
  localparam logic [IDX_WIDTH-1:0] CLS_1 = IDX_WIDTH'(1);
  localparam logic [IDX_WIDTH-1:0] CLS_2 = IDX_WIDTH'(2);
  localparam logic [IDX_WIDTH-1:0] CLS_3 = IDX_WIDTH'(3);
  localparam logic [IDX_WIDTH-1:0] CLS_4 = IDX_WIDTH'(4);
  localparam logic [IDX_WIDTH-1:0] CLS_5 = IDX_WIDTH'(5);
  localparam logic [IDX_WIDTH-1:0] CLS_6 = IDX_WIDTH'(6);
endpackage

// File: rtl/dense_argmax_if.sv
// dense_argmax_if: score-vector input and classification result bundle
// master drives data_i/valid_i and observes busy/result/drop; slave is the argmax block.
interface dense_argmax_if;
  import dense_pkg::*;
  logic [DATA_WIDTH*NUM_CLASS-1:0] data_i;
  logic                            valid_i;
  logic                            busy_o;
  logic [IDX_WIDTH-1:0]            class_o;
  logic [DATA_WIDTH-1:0]           score_o;
  logic                            valid_o;
  logic                            drop_o;
  modport master (output data_i, valid_i, input busy_o, class_o, score_o, valid_o, drop_o);
  modport slave  (input data_i, valid_i, output busy_o, class_o, score_o, valid_o, drop_o);
endinterface

// File: rtl/dense_argmax.sv
// dense_argmax: serial signed argmax over NUM_CLASS packed scores, one class per cycle
// Ports: clk, rstn (async active-low), bus (slave): data_i/valid_i in,
// busy_o/class_o/score_o/valid_o/drop_o out.
module dense_argmax
  import dense_pkg::*;
(
  input logic           clk,
  input logic           rstn,
  dense_argmax_if.slave bus
);
  state_t                          state_q;
  logic [DATA_WIDTH*NUM_CLASS-1:0] data_q;
  logic [DATA_WIDTH-1:0]           best_q, best_d, score_q;
  logic [IDX_WIDTH-1:0]            idx_q, idx_d, cnt_q, class_q;
  logic                            valid_q, drop_q, gt;
  logic signed [DATA_WIDTH-1:0]    cur;
  // strict greater-than keeps the lower index on ties
  always_comb begin
    cur    = $signed(data_q[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH]);
    gt     = cur > $signed(best_q);
    best_d = gt ? cur : best_q;
    idx_d  = gt ? cnt_q : idx_q;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      data_q  <= '0;
      best_q  <= '0;
      idx_q   <= CLS_0;
      cnt_q   <= '0;
      class_q <= CLS_0;
      score_q <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
      if (state_q == IDLE) begin
        if (bus.valid_i) begin
          data_q  <= bus.data_i;
          best_q  <= bus.data_i[DATA_WIDTH-1:0];
          idx_q   <= CLS_0;
          cnt_q   <= IDX_WIDTH'(1);
          state_q <= SCAN;
        end
      end else begin
        drop_q <= bus.valid_i;
        best_q <= best_d;
        idx_q  <= idx_d;
        cnt_q  <= cnt_q + 1'b1;
        // final compare goes straight to the outputs; no separate done state
        if (cnt_q == IDX_WIDTH'(NUM_CLASS-1)) begin
          class_q <= idx_d;
          score_q <= best_d;
          valid_q <= 1'b1;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      end
    end
  end
  assign bus.busy_o  = (state_q == SCAN);
  assign bus.class_o = class_q;
  assign bus.score_o = score_q;
  assign bus.valid_o = valid_q;
  assign bus.drop_o  = drop_q;
endmodule

// File: tb/tb_dense_argmax.sv
// tb_dense_argmax: randomized and directed self-checking bench for dense_argmax
module tb_dense_argmax;
  import dense_pkg::*;
  typedef int vec_t [NUM_CLASS];
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int total = 0;
  int bad = 0;
  dense_argmax_if bus ();
  dense_argmax dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic void ref_argmax(input vec_t s, output int c, output int m);
    c = 0;
    m = s[0];
    for (int i = 1; i < NUM_CLASS; i++) if (s[i] > m) begin m = s[i]; c = i; end
  endfunction
  function automatic logic [DATA_WIDTH*NUM_CLASS-1:0] pack(input vec_t s);
    logic [DATA_WIDTH*NUM_CLASS-1:0] p;
    int v;
    for (int i = 0; i < NUM_CLASS; i++) begin
      v = s[i];
      p[i*DATA_WIDTH +: DATA_WIDTH] = v[DATA_WIDTH-1:0];
    end
    return p;
  endfunction
  function automatic int sc();
    return int'($signed(bus.score_o));
  endfunction
  task automatic pulse(input vec_t s);
    bus.data_i  = pack(s);
    bus.valid_i = 1'b1;
  endtask
  task automatic await_result(input string tag, input vec_t s);
    int c, m;
    ref_argmax(s, c, m);
    for (int k = 1; k <= NUM_CLASS; k++) begin
      @(posedge clk);
      @(negedge clk);
      bus.valid_i = 1'b0;
      chk({tag, ".drop"}, int'(bus.drop_o), 0);
      if (k < NUM_CLASS) begin
        chk({tag, ".busy"}, int'(bus.busy_o), 1);
        chk({tag, ".early_valid"}, int'(bus.valid_o), 0);
      end else begin
        chk({tag, ".valid"}, int'(bus.valid_o), 1);
        chk({tag, ".busy_end"}, int'(bus.busy_o), 0);
        chk({tag, ".class"}, int'(bus.class_o), c);
        chk({tag, ".score"}, sc(), m);
      end
    end
  endtask
  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".idle_valid"}, int'(bus.valid_o), 0);
      chk({tag, ".idle_busy"}, int'(bus.busy_o), 0);
    end
  endtask
  initial begin
    vec_t v1, v2, v3, v4, v5, r;
    int c, m;
    v1 = '{3, -5, 10, 2, 40, -1, 7};
    v2 = '{12, 12, -3, 12, 0, 0, 0};
    v3 = '{0, 0, 0, 0, 0, 0, 5};
    v4 = '{-100, -128, -7, -50, -7, -90, -128};
    v5 = '{-128, -128, -128, -128, -128, -128, -128};
    bus.data_i  = '0;
    bus.valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.busy", int'(bus.busy_o), 0);
    chk("rst.class", int'(bus.class_o), 0);
    chk("rst.score", sc(), 0);
    chk("rst.valid", int'(bus.valid_o), 0);
    chk("rst.drop", int'(bus.drop_o), 0);
    rstn = 1'b1;
    idle("pre", 2);
    pulse(v1); await_result("basic", v1); idle("basic", 1);
    pulse(v2); await_result("tie", v2); idle("tie", 1);
    pulse(v3); await_result("last", v3); idle("last", 1);
    pulse(v5); await_result("allmin", v5); idle("allmin", 1);
    pulse(v1); await_result("b2b_a", v1);
    pulse(v4); await_result("b2b_b", v4); idle("b2b", 1);
    ref_argmax(v3, c, m);
    pulse(v3);
    for (int k = 1; k <= NUM_CLASS; k++) begin
      @(posedge clk);
      @(negedge clk);
      bus.valid_i = 1'b0;
      if (k == 3) pulse(v1);
      chk("drop.pulse", int'(bus.drop_o), int'(k == 4));
      if (k == NUM_CLASS) begin
        chk("drop.valid", int'(bus.valid_o), 1);
        chk("drop.class", int'(bus.class_o), c);
        chk("drop.score", sc(), m);
      end
    end
    idle("drop", 8);
    chk("drop.hold_class", int'(bus.class_o), c);
    pulse(v4); await_result("prerst", v4); idle("prerst", 1);
    pulse(v1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      bus.valid_i = 1'b0;
    end
    rstn = 1'b0;
    #1;
    chk("rst_mid.class", int'(bus.class_o), 0);
    chk("rst_mid.score", sc(), 0);
    chk("rst_mid.busy", int'(bus.busy_o), 0);
    @(negedge clk);
    rstn = 1'b1;
    idle("rst_mid", 8);
    chk("rst_mid.class_after", int'(bus.class_o), 0);
    pulse(v2); await_result("postrst", v2); idle("postrst", 1);
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NUM_CLASS; i++)
        r[i] = (n % 3 == 0) ? int'($urandom_range(0, 3)) - 2 : int'($urandom_range(0, 255)) - 128;
      pulse(r);
      await_result("rand", r);
      if ($urandom_range(0, 1) == 1) idle("rand", int'($urandom_range(1, 3)));
    end
    idle("end", 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
